// File: rtl/spm_pkg.sv
// Shared definitions for the stored-program machine memory side.
// Holds the responder state encoding and the instruction opcodes used by
// the control unit and the benches.
package spm_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } resp_state_t;

    localparam logic [3:0] NOP  = 4'b0000;
    localparam logic [3:0] ADD  = 4'b0001;
    localparam logic [3:0] SUB  = 4'b0010;
    localparam logic [3:0] AND  = 4'b0011;
    localparam logic [3:0] NOT  = 4'b0100;
    localparam logic [3:0] RD   = 4'b0101;
    localparam logic [3:0] WR   = 4'b0110;
    localparam logic [3:0] BR   = 4'b0111;
    localparam logic [3:0] BRZ  = 4'b1000;
    localparam logic [3:0] HALT = 4'b1111;

endpackage

// File: rtl/spm_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read.
// Ports: clk; we/waddr/wdata write port; raddr/rdata combinational read.
// Contents are intentionally not reset.
module spm_ram #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/spm_memory_responder.sv
// Memory-side responder for the stored-program machine.
// CPU side: bus_2/load_add_r load the address register, bus_1/write commit a
// word, mem_word is the combinational read of mem[add_r].
// Loader side: ld_start begins a byte-stream fill from address 0 with a
// valid/ready handshake (ld_valid, ld_data, ld_last, ld_ready); ld_done pulses
// at the end, ld_err flags overflow, cpu_hold keeps the CPU in reset meanwhile.
module spm_memory_responder
    import spm_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_2,
    input  logic [DATA_W-1:0] bus_1,
    input  logic              load_add_r,
    input  logic              write,
    output logic [DATA_W-1:0] mem_word,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              ld_err,
    output logic              cpu_hold
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    resp_state_t       state;
    logic [ADDR_W-1:0] add_r;
    logic [ADDR_W-1:0] ptr;

    logic              xfer;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    assign xfer = (state == LOAD) && ld_valid;

    // Write port mux: the loader owns the port during LOAD, the CPU only in RUN.
    // Gating with rst keeps a reset edge from committing a stray write.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = add_r;
        ram_wdata = bus_1;
        if (state == LOAD) begin
            ram_we    = xfer && !rst;
            ram_waddr = ptr;
            ram_wdata = ld_data;
        end else if (state == RUN) begin
            ram_we    = write && !rst;
        end
    end

    spm_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(add_r),
        .rdata(mem_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            add_r    <= '0;
            ptr      <= '0;
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
            ld_err   <= 1'b0;
            cpu_hold <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    ld_done <= 1'b0;
                    if (load_add_r) begin
                        add_r <= bus_2;
                    end
                    if (ld_start) begin
                        state    <= LOAD;
                        ptr      <= '0;
                        ld_err   <= 1'b0;
                        cpu_hold <= 1'b1;
                        ld_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        ptr <= ptr + 1'b1;
                        // Ending at the top address stops the fill before ptr
                        // wraps, so address 0 is never overwritten.
                        if (ld_last || (ptr == LAST_ADDR)) begin
                            state    <= FINISH;
                            ld_ready <= 1'b0;
                            ld_done  <= 1'b1;
                            if (!ld_last) begin
                                ld_err <= 1'b1;
                            end
                        end
                    end
                end
                FINISH: begin
                    add_r    <= '0;
                    ld_done  <= 1'b0;
                    cpu_hold <= 1'b0;
                    state    <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spm_memory_responder.sv
module tb_spm_memory_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bus_2;
    logic [7:0] bus_1;
    logic       load_add_r;
    logic       write;
    logic [7:0] mem_word;
    logic       ld_start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic       ld_done;
    logic       ld_err;
    logic       cpu_hold;

    int total = 0;
    int bad   = 0;
    int hold_cnt;
    int done_cnt;

    always #5 clk = ~clk;

    spm_memory_responder #(
        .ADDR_W(8),
        .DATA_W(8),
        .DEPTH (256)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_2     (bus_2),
        .bus_1     (bus_1),
        .load_add_r(load_add_r),
        .write     (write),
        .mem_word  (mem_word),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .ld_done   (ld_done),
        .ld_err    (ld_err),
        .cpu_hold  (cpu_hold)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input logic [7:0] a);
        load_add_r = 1'b1;
        bus_2      = a;
        tick();
        load_add_r = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        set_addr(a);
        write = 1'b1;
        bus_1 = d;
        tick();
        write = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        set_addr(a);
        chk(tag, mem_word, exp);
    endtask

    initial begin
        rst = 1'b1; bus_2 = '0; bus_1 = '0; load_add_r = 1'b0; write = 1'b0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        tick();
        tick();
        chk("rst_cpu_hold", {7'd0, cpu_hold}, 8'd0);
        chk("rst_ld_ready", {7'd0, ld_ready}, 8'd0);
        chk("rst_ld_done",  {7'd0, ld_done},  8'd0);
        chk("rst_ld_err",   {7'd0, ld_err},   8'd0);
        rst = 1'b0;

        // add_r resets to 0: a write without loading an address lands at 0
        write = 1'b1; bus_1 = 8'h77;
        tick();
        write = 1'b0;
        chk("rst_addr_zero", mem_word, 8'h77);

        // CPU access
        cpu_write(8'h11, 8'h6E);
        cpu_write(8'h20, 8'h99);
        cpu_write(8'h40, 8'h44);
        cpu_write(8'h10, 8'hA5);
        chk("cpu_wr_rd", mem_word, 8'hA5);
        read_chk("cpu_old_11", 8'h11, 8'h6E);

        // same-cycle write + address load, write uses old add_r
        set_addr(8'h05);
        write = 1'b1; bus_1 = 8'h3C; load_add_r = 1'b1; bus_2 = 8'h20;
        tick();
        write = 1'b0; load_add_r = 1'b0;
        chk("same_cyc_new_addr", mem_word, 8'h99);
        read_chk("same_cyc_mem05", 8'h05, 8'h3C);

        // program load of 4 bytes, add_r left at 0x10 beforehand
        set_addr(8'h10);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("ld_hold_on", {7'd0, cpu_hold}, 8'd1);
        chk("ld_ready_on", {7'd0, ld_ready}, 8'd1);
        hold_cnt = 1;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_last  = (i == 3);
            case (i)
                0: ld_data = 8'h51;
                1: ld_data = 8'h01;
                2: ld_data = 8'h52;
                default: ld_data = 8'hF0;
            endcase
            tick();
            if (cpu_hold) hold_cnt++;
            if (ld_done) done_cnt++;
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("fin_ready_low", {7'd0, ld_ready}, 8'd0);
        chk("fin_done_high", {7'd0, ld_done}, 8'd1);
        tick();
        if (cpu_hold) hold_cnt++;
        if (ld_done) done_cnt++;
        chk("ld_hold_cycles", 8'(hold_cnt), 8'd5);
        chk("ld_done_pulses", 8'(done_cnt), 8'd1);
        chk("ld_release", {7'd0, cpu_hold}, 8'd0);
        chk("ld_addr_cleared", mem_word, 8'h51);
        read_chk("ld_mem1", 8'h01, 8'h01);
        read_chk("ld_mem2", 8'h02, 8'h52);
        read_chk("ld_mem3", 8'h03, 8'hF0);

        // ld_start with write in the same cycle, then gaps and ignored strobes
        set_addr(8'h30);
        write = 1'b1; bus_1 = 8'hC3; ld_start = 1'b1;
        tick();
        write = 1'b0; ld_start = 1'b0;
        chk("start_write_commit", mem_word, 8'hC3);
        write = 1'b1; bus_1 = 8'hEE; load_add_r = 1'b1; bus_2 = 8'h40;
        tick();
        write = 1'b0; load_add_r = 1'b0;
        chk("load_cpu_ignored", mem_word, 8'hC3);
        ld_valid = 1'b1; ld_data = 8'hA1;
        tick();
        ld_valid = 1'b0; ld_data = 8'hFF;
        tick();
        tick();
        chk("gap_ready", {7'd0, ld_ready}, 8'd1);
        ld_valid = 1'b1; ld_data = 8'hA2; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        tick();
        read_chk("bp_mem0", 8'h00, 8'hA1);
        read_chk("bp_mem1", 8'h01, 8'hA2);
        read_chk("bp_mem2", 8'h02, 8'h52);
        read_chk("bp_mem40", 8'h40, 8'h44);
        read_chk("bp_mem30", 8'h30, 8'hC3);

        // overflow: 256 bytes with no ld_last
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'(i) ^ 8'h3C;
            tick();
            if (i == 254) begin
                chk("ovf_pre_err", {7'd0, ld_err}, 8'd0);
                chk("ovf_pre_ready", {7'd0, ld_ready}, 8'd1);
            end
        end
        ld_valid = 1'b0;
        chk("ovf_err", {7'd0, ld_err}, 8'd1);
        chk("ovf_done", {7'd0, ld_done}, 8'd1);
        chk("ovf_ready_low", {7'd0, ld_ready}, 8'd0);
        tick();
        chk("ovf_err_sticky", {7'd0, ld_err}, 8'd1);
        chk("ovf_released", {7'd0, cpu_hold}, 8'd0);
        chk("ovf_mem0", mem_word, 8'h3C);
        read_chk("ovf_mem255", 8'hFF, 8'hC3);
        read_chk("ovf_mem80", 8'h80, 8'hBC);

        // reset mid-load after 2 of 4 bytes
        cpu_write(8'h02, 8'h22);
        cpu_write(8'h03, 8'h33);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("start_clears_err", {7'd0, ld_err}, 8'd0);
        ld_valid = 1'b1; ld_data = 8'hD0;
        tick();
        ld_data = 8'hD1;
        tick();
        ld_data = 8'hD2; rst = 1'b1;
        tick();
        rst = 1'b0; ld_valid = 1'b0;
        chk("abort_hold", {7'd0, cpu_hold}, 8'd0);
        chk("abort_ready", {7'd0, ld_ready}, 8'd0);
        chk("abort_done", {7'd0, ld_done}, 8'd0);
        read_chk("abort_mem0", 8'h00, 8'hD0);
        read_chk("abort_mem1", 8'h01, 8'hD1);
        read_chk("abort_mem2", 8'h02, 8'h22);
        read_chk("abort_mem3", 8'h03, 8'h33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spm_memory_responder.md
# spm_memory_responder

Memory-side responder for the RISC stored-program machine. It answers the control unit's memory commands: it captures the address on `load_add_r`, returns `mem_word` to the Bus_2 mux, and commits `write` cycles. It also has a byte-stream program-load port. While a load runs, the block holds the CPU in reset and fills memory from address 0.

## Interface
- `ADDR_W`, 8: width of the address register and the memory address.
- `DATA_W`, 8: width of a memory word and of the instruction word.
- `DEPTH`, 256: number of memory words; must equal 2**ADDR_W.
- Clock and reset: one clock; reset is synchronous and active-high (`clk`, `rst`).
- `clk`  in  1  system clock, shared with the control unit.
- `rst`  in  1  synchronous active-high reset.
- `bus_2`  in  DATA_W  Bus_2 value; source of the address when `load_add_r`=1.
- `bus_1`  in  DATA_W  Bus_1 value; write data.
- `load_add_r`  in  1  capture `bus_2` into the address register.
- `write`  in  1  write `bus_1` to mem[address register].
- `mem_word`  out  DATA_W  mem[address register]; combinational read.
- `ld_start`  in  1  one-cycle pulse that begins a program load.
- `ld_valid`  in  1  `ld_data` is valid.
- `ld_data`  in  DATA_W  program byte.
- `ld_last`  in  1  qualifies the final byte of the stream.
- `ld_ready`  out  1  the block accepts a byte this cycle.
- `ld_done`  out  1  one-cycle pulse at the end of a load.
- `ld_err`  out  1  sticky flag: the load overflowed DEPTH; cleared by `rst` or the next `ld_start`.
- `cpu_hold`  out  1  active-high reset request to the control unit and the datapath.

## Operation
- States: RUN, LOAD, FINISH. Reset enters RUN.
- RUN
  - `load_add_r`=1: add_r <= `bus_2`.
  - `write`=1: mem[add_r] <= `bus_1`, using the add_r value from before this edge. This also holds when `load_add_r` is asserted in the same cycle.
  - `ld_start`=1: go to LOAD. Same edge: ptr <= 0, ld_err <= 0.
- LOAD
  - `cpu_hold`=1 and `ld_ready`=1.
  - `load_add_r` and `write` are ignored.
  - On a transfer (`ld_valid` & `ld_ready`): mem[ptr] <= `ld_data`, ptr <= ptr+1 (wraps at DEPTH).
  - Transfer with `ld_last`=1: go to FINISH.
  - Transfer at ptr = DEPTH-1 with `ld_last`=0: ld_err <= 1, go to FINISH. No write wraps back to address 0.
  - `ld_start` is ignored.
- FINISH (one cycle)
  - `cpu_hold`=1, `ld_ready`=0, `ld_done`=1.
  - add_r <= 0, so the first fetch after release is well defined.
  - Then go to RUN.
- `mem_word` always shows mem[add_r], including during LOAD.
- Memory contents are never reset.
- Reset in the middle of a load aborts it: state RUN, `cpu_hold`=0. Bytes already written stay in memory.

## Timing
- Reset values: add_r=0, ptr=0, `ld_ready`=0, `ld_done`=0, `ld_err`=0, `cpu_hold`=0.
- Read latency is 0 cycles from add_r: an address loaded in fet1 is readable in fet2. The same applies to rd1/rd2, wr1/wr2 and br1/br2.
- Write takes effect at the clock edge. A read in the next cycle returns the new data.
- Handshake: a byte transfers when `ld_valid` and `ld_ready` are both high at the edge. `ld_ready` is high on every LOAD cycle.
- Load cost: N bytes take N transfer cycles plus 1 FINISH cycle. `cpu_hold` falls on the edge after FINISH.
- `ld_start` arriving the same cycle as `write`: the write commits, and LOAD begins on that edge.

## Structure
- `spm_pkg` holds:
  - the state encoding (RUN/LOAD/FINISH);
  - the opcode constants NOP..HALT, shared with the control unit and the benches.
- Sub-module `spm_ram`: DEPTH x DATA_W storage with one synchronous write port and an asynchronous read port. Its write port is muxed between the CPU path (add_r, `bus_1`) and the loader path (ptr, `ld_data`).
- The top level holds the FSM, add_r, ptr and the flags.

## Test plan
- CPU access: `load_add_r` with `bus_2`=0x10, then `write` with `bus_1`=0xA5 → next cycle `mem_word`=0xA5. Then load address 0x11 → `mem_word` shows the old contents of address 0x11.
- Same-cycle update: `write` with `bus_1`=0x3C and `load_add_r` with `bus_2`=0x20, both at add_r=0x05 → mem[0x05]=0x3C; add_r=0x20.
- Program load: `ld_start`, then 4 bytes 0x51,0x01,0x52,0xF0 with `ld_last` on the 4th → mem[0..3] holds those bytes. `cpu_hold` is high for 5 cycles, `ld_done` pulses once, add_r=0, then `mem_word`=0x51.
- Backpressure and ignored CPU strobes: `ld_valid` gaps mid-load, plus `write`=1 during LOAD → no extra writes, no CPU write commits, ptr advances only on transfers.
- Overflow: 256 bytes without `ld_last` → `ld_err`=1 after the 256th transfer, FINISH entered, mem[0] holds byte 0 (not overwritten). The next `ld_start` clears `ld_err`.
- Reset mid-load: `rst` after 2 of 4 bytes → `cpu_hold`=0, `ld_ready`=0, state RUN, mem[0..1] written, mem[2..3] unchanged.
